cmu: RTL

CMU -- requirements
Module: cmu

---
 rtl/cmu_pkg.sv | 11 +
 rtl/cmu_if.sv | 7 +
 rtl/cmu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cmu_pkg.sv
// cmu_pkg: address geometry shared by the cache management unit and its environment
package cmu_pkg;
  localparam int TAG_BITS = 23;
  localparam int IDX_BITS = 5;
  localparam int ELEMENT_WORDS = 4;
  localparam int WCNT_BITS = $clog2(ELEMENT_WORDS);
  function automatic logic [31:0] word_addr(input logic [TAG_BITS-1:0] tag, input logic [IDX_BITS-1:0] idx,
                                            input logic [WCNT_BITS-1:0] w);
    return {tag, idx, w, 2'b00};
  endfunction
endpackage

// File: rtl/cmu_if.sv
// cmu_if: word-wide memory bus between the cache management unit and backing memory
interface cmu_if;
  logic        mem_cs_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  modport master(output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o, input mem_data_i, mem_ack_i);
  modport slave(input mem_cs_o, mem_we_o, mem_addr_o, mem_data_o, output mem_data_i, mem_ack_i);
endinterface

// File: rtl/cmu.sv
// cmu: write-back cache controller sequencing CPU hits, victim write-back and line fill
module cmu
  import cmu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr_rw,
  input  logic                en_r,
  input  logic                en_w,
  input  logic [2:0]          u_b_h_w,
  input  logic [31:0]         data_w,
  output logic [31:0]         data_r,
  output logic                stall,
  output logic [31:0]         cache_addr,
  output logic                cache_load,
  output logic                cache_store,
  output logic                cache_edit,
  output logic                cache_invalid,
  output logic [2:0]          cache_u_b_h_w,
  output logic [31:0]         cache_din,
  input  logic [31:0]         cache_dout,
  input  logic                cache_hit,
  input  logic                cache_valid,
  input  logic                cache_dirty,
  input  logic [TAG_BITS-1:0] cache_tag,
  cmu_if.master               mem
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CMP = 3'd1, S_BACK_RD = 3'd2, S_BACK_WR = 3'd3, S_FILL = 3'd4, S_WAIT = 3'd5;
  logic [2:0]          state_q, state_d;
  logic [WCNT_BITS-1:0] wcnt_q, wcnt_d;
  logic [TAG_BITS-1:0] vtag_q, vtag_d;
  logic [31:0]         wd_q, wd_d, data_r_q, data_r_d;
  logic                ent_q, ent_d;
  logic                req, last;
  logic [IDX_BITS-1:0] idx;
  assign req = en_r | en_w;
  assign idx = addr_rw[8:4];
  assign last = wcnt_q == WCNT_BITS'(ELEMENT_WORDS - 1);
  assign data_r = data_r_q;
  assign cache_invalid = 1'b0;
  assign cache_u_b_h_w = rst ? u_b_h_w : 3'b000;
  // state register; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q <= '0;
      vtag_q <= '0;
      wd_q <= '0;
      data_r_q <= '0;
      ent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      vtag_q <= vtag_d;
      wd_q <= wd_d;
      data_r_q <= data_r_d;
      ent_q <= ent_d;
    end
  // next state: victim tag captured at compare, victim word captured on the first write-back cycle
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    vtag_d = vtag_q;
    wd_d = ent_q ? cache_dout : wd_q;
    data_r_d = data_r_q;
    ent_d = state_q == S_BACK_RD;
    case (state_q)
      S_IDLE: state_d = req ? S_CMP : S_IDLE;
      S_CMP: begin
        vtag_d = cache_tag;
        data_r_d = (cache_hit && en_r && !en_w) ? cache_dout : data_r_q;
        wcnt_d = cache_hit ? wcnt_q : '0;
        state_d = cache_hit ? S_IDLE : (cache_valid && cache_dirty) ? S_BACK_RD : S_FILL;
      end
      S_BACK_RD: state_d = S_BACK_WR;
      S_BACK_WR: if (mem.mem_ack_i) begin
        wcnt_d = last ? '0 : wcnt_q + 1'b1;
        state_d = last ? S_FILL : S_BACK_RD;
      end
      S_FILL: if (mem.mem_ack_i) begin
        wcnt_d = last ? '0 : wcnt_q + 1'b1;
        state_d = last ? S_WAIT : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // outputs: cache and memory controls per state, all forced low while reset is held
  always_comb begin
    stall = 1'b1;
    cache_addr = addr_rw;
    cache_load = 1'b0;
    cache_store = 1'b0;
    cache_edit = 1'b0;
    cache_din = data_w;
    mem.mem_cs_o = 1'b0;
    mem.mem_we_o = 1'b0;
    mem.mem_addr_o = '0;
    mem.mem_data_o = '0;
    case (state_q)
      S_IDLE: begin
        stall = req;
        cache_edit = en_w;
        cache_load = en_r & ~en_w;
      end
      S_CMP: stall = ~cache_hit;
      S_BACK_RD: cache_addr = word_addr(vtag_q, idx, wcnt_q);
      S_BACK_WR: begin
        cache_addr = word_addr(vtag_q, idx, wcnt_q);
        mem.mem_cs_o = 1'b1;
        mem.mem_we_o = 1'b1;
        mem.mem_addr_o = word_addr(vtag_q, idx, wcnt_q);
        mem.mem_data_o = ent_q ? cache_dout : wd_q;
      end
      S_FILL: begin
        cache_addr = word_addr(addr_rw[31:9], idx, wcnt_q);
        cache_store = mem.mem_ack_i;
        cache_din = mem.mem_data_i;
        mem.mem_cs_o = 1'b1;
        mem.mem_addr_o = word_addr(addr_rw[31:9], idx, wcnt_q);
      end
      default: ;
    endcase
    if (!rst) begin
      stall = 1'b0;
      cache_addr = '0;
      cache_load = 1'b0;
      cache_store = 1'b0;
      cache_edit = 1'b0;
      cache_din = '0;
      mem.mem_cs_o = 1'b0;
      mem.mem_we_o = 1'b0;
      mem.mem_addr_o = '0;
      mem.mem_data_o = '0;
    end
  end
endmodule
